div_8bit_seq: RTL and testbench

DIV_8BIT_SEQ -- requirements
Module: div_8bit_seq

---
 rtl/div_8bit_seq.sv | 134 +++++++++++++
 tb/tb_div_8bit_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_8bit_seq.sv
// Sequential restoring divider, signed or unsigned. Latency WIDTH+1 cycles (1 for divide-by-zero).
// No backpressure: start is only sampled while idle; starts seen while busy are dropped, never queued.
module div_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_q;    // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem;
    logic             q_neg, r_neg, ovf_pending;

    logic             dvd_neg_in, dvs_neg_in;
    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
    logic             ovf_in;
    logic [WIDTH+1:0] rem_sh, diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] q_mag, q_fin, r_fin;
    logic             last_step;

    // Operand conditioning at acceptance; the most-negative value keeps magnitude 2^(WIDTH-1).
    always_comb begin
        dvd_neg_in = signed_mode & dividend[WIDTH-1];
        dvs_neg_in = signed_mode & divisor[WIDTH-1];
        dvd_mag_in = dvd_neg_in ? (~dividend + 1'b1) : dividend;
        dvs_mag_in = dvs_neg_in ? (~divisor + 1'b1) : divisor;
        ovf_in     = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    end

    // One restoring step; sign bit of the widened difference decides keep vs restore.
    always_comb begin
        rem_sh    = {rem, dvd_q[WIDTH-1]};
        diff      = rem_sh - {2'b00, dvs_mag};
        q_bit     = ~diff[WIDTH+1];
        rem_nxt   = q_bit ? diff[WIDTH:0] : rem_sh[WIDTH:0];
        q_mag     = {dvd_q[WIDTH-2:0], q_bit};
        q_fin     = q_neg ? (~q_mag + 1'b1) : q_mag;
        r_fin     = r_neg ? (~rem_nxt[WIDTH-1:0] + 1'b1) : rem_nxt[WIDTH-1:0];
        last_step = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvd_q       <= '0;
            dvs_mag     <= '0;
            rem         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_pending <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        dvd_q       <= dvd_mag_in;
                        dvs_mag     <= dvs_mag_in;
                        rem         <= '0;
                        q_neg       <= dvd_neg_in ^ dvs_neg_in;
                        r_neg       <= dvd_neg_in;
                        ovf_pending <= ovf_in;
                        // Divide-by-zero skips iteration; results land in time for the next-cycle done.
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            zero        <= 1'b0;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    cnt   <= cnt + 1'b1;
                    dvd_q <= q_mag;
                    rem   <= rem_nxt;
                    if (last_step) begin
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        zero        <= (q_fin == '0);
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_pending;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_8bit_seq.sv
// Randomized bench for div_8bit_seq against an arithmetic reference model.
module tb_div_8bit_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       signed_mode;
    logic [7:0] dividend, divisor;
    logic       busy, done, zero, div_by_zero, overflow;
    logic [7:0] quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] last_pack;  // {q, r, zero, dbz, ovf} from the most recent completed divide

    div_8bit_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .zero(zero), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge (cycle T); returns at the negedge of cycle T+lat+1.
    task automatic do_div(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] spam);
        logic [7:0] eq, er;
        logic       ez, edz, eov;
        int         lat, sa, sb;
        if (b == 8'h00) begin
            eq = 8'hFF; er = a; edz = 1'b1; eov = 1'b0; lat = 1;
        end else begin
            edz = 1'b0; lat = 9;
            if (sm) begin
                sa  = int'($signed(a));
                sb  = int'($signed(b));
                eq  = 8'(sa / sb);
                er  = 8'(sa % sb);
                eov = (sa == -128) && (sb == -1);
            end else begin
                eq  = a / b;
                er  = a % b;
                eov = 1'b0;
            end
        end
        ez = (eq == 8'h00);

        start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("busy", 32'(busy), 1);
            check("done", 32'(done), 32'(k == lat));
            if (k < lat) begin
                check("hold", 32'({quotient, remainder, zero, div_by_zero, overflow}), 32'(last_pack));
            end else begin
                check("quotient",    32'(quotient),    32'(eq));
                check("remainder",   32'(remainder),   32'(er));
                check("zero",        32'(zero),        32'(ez));
                check("div_by_zero", 32'(div_by_zero), 32'(edz));
                check("overflow",    32'(overflow),    32'(eov));
            end
            // Scramble inputs after acceptance; any start raised here must be dropped.
            start       = spam[k];
            signed_mode = 1'($urandom);
            dividend    = 8'($urandom);
            divisor     = 8'($urandom);
        end
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        start     = 1'b0;
        last_pack = {eq, er, ez, edz, eov};
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = 8'h00; divisor = 8'h00;
        last_pack = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_outs", 32'({quotient, remainder, zero, div_by_zero, overflow}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(1'b0, 8'd100, 8'd7,  16'h0000);
        do_div(1'b1, 8'hF9,  8'h02, 16'h0000);
        do_div(1'b1, 8'h07,  8'hFE, 16'h0000);
        do_div(1'b0, 8'h55,  8'h00, 16'h0000);
        do_div(1'b1, 8'h55,  8'h00, 16'h0000);
        do_div(1'b1, 8'h80,  8'hFF, 16'h0000);
        do_div(1'b0, 8'h80,  8'hFF, 16'h0000);
        // Starts at T+3 and in the done cycle are ignored; next call starts at T+10.
        do_div(1'b0, 8'd100, 8'd7,  16'h0208);
        do_div(1'b1, 8'h80,  8'h01, 16'h0000);
        do_div(1'b1, 8'h81,  8'h80, 16'h0000);
        do_div(1'b0, 8'hFF,  8'h01, 16'h0000);
        do_div(1'b0, 8'h00,  8'h05, 16'h0000);

        // Reset in the middle of CALC aborts without a done.
        start = 1'b1; signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd3;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("mid_busy", 32'(busy), 1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_outs", 32'({quotient, remainder, zero, div_by_zero, overflow}), 0);
        rst_n = 1'b1;
        last_pack = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_nodone", 32'(done), 0);
            check("abort_idle",   32'(busy), 0);
        end
        do_div(1'b0, 8'd9, 8'd3, 16'h0000);

        // Start coinciding with reset is ignored.
        rst_n = 1'b0; start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_start_idle", 32'(busy), 0);
        check("rst_start_done", 32'(done), 0);
        last_pack = '0;

        for (int i = 0; i < 150; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = (i % 10 == 0) ? 8'h00 : 8'($urandom);
            if (i % 17 == 0) begin a = 8'h80; b = 8'hFF; end
            do_div(1'($urandom), a, b, 16'($urandom) & 16'hFFFE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule
